// File: rtl/ball_sequencer_if.sv
// ============================================================================
//  Module      : ball_sequencer_if
//  Description : Handshake/status bundle between the ball sequencer and the
//                board controller that drives it.
//                Controller -> sequencer : start, start_color, blue_lever,
//                                          red_lever
//                Sequencer -> controller : blue_release, red_release,
//                                          current_color, busy, no_balls,
//                                          timeout_err, halted, tray,
//                                          tray_amount
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ball_sequencer_if;
  logic       start;
  logic       start_color;
  logic       blue_lever;
  logic       red_lever;
  logic       blue_release;
  logic       red_release;
  logic       current_color;
  logic       busy;
  logic       no_balls;
  logic       timeout_err;
  logic       halted;
  logic [5:0] tray;
  logic [2:0] tray_amount;

  // Controller side
  modport master (
    output start, start_color, blue_lever, red_lever,
    input  blue_release, red_release, current_color, busy, no_balls,
           timeout_err, halted, tray, tray_amount
  );

  // Sequencer side
  modport slave (
    input  start, start_color, blue_lever, red_lever,
    output blue_release, red_release, current_color, busy, no_balls,
           timeout_err, halted, tray, tray_amount
  );
endinterface

`default_nettype wire

// File: rtl/ball_sequencer.sv
// ============================================================================
//  Module      : ball_sequencer
//  Description : Drops coloured balls onto a board one at a time. The first
//                ball is launched by start; each ball landing on a lever picks
//                the colour of the next ball. Landed colours are logged in a
//                six-entry tray. Running out of a colour or a ball that never
//                lands stops the sequencer in HALT until reset.
//  Ports       : clk  - clock, all logic on rising edge
//                rst  - synchronous active-high reset
//                bus  - ball_sequencer_if.slave (start/levers in,
//                       releases/status/tray out)
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ball_sequencer #(
  parameter int AMOUNT_BLUE = 8,   // blue balls loaded at reset (1..31)
  parameter int AMOUNT_RED  = 8,   // red balls loaded at reset (1..31)
  parameter int TIMEOUT     = 255  // max cycles a ball may be in flight (1..255)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ball_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RELEASE = 2'd1,
    FLIGHT  = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [4:0] C_BLUE_INIT = 5'(AMOUNT_BLUE);
  localparam logic [4:0] C_RED_INIT  = 5'(AMOUNT_RED);
  localparam logic [7:0] C_TIMEOUT   = 8'(TIMEOUT);
  localparam logic [2:0] C_TRAY_SIZE = 3'd6;

  state_t     state;
  logic [4:0] blues;
  logic [4:0] reds;
  logic [7:0] flight_timer;

  // A ball request comes either from start (IDLE) or from a lever (FLIGHT).
  // Blue lever wins when both levers fire together.
  logic req;
  logic req_color;
  logic req_avail;

  always_comb begin
    req       = 1'b0;
    req_color = 1'b0;
    if (state == IDLE && bus.start) begin
      req       = 1'b1;
      req_color = bus.start_color;
    end else if (state == FLIGHT && (bus.blue_lever || bus.red_lever)) begin
      req       = 1'b1;
      req_color = !bus.blue_lever;
    end
    req_avail = req_color ? (reds != 5'd0) : (blues != 5'd0);
  end

  // The RELEASE actions are registered on the edge that enters RELEASE, so
  // the release pulse, the decremented supply and current_color are all
  // visible during the single RELEASE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      blues             <= C_BLUE_INIT;
      reds              <= C_RED_INIT;
      flight_timer      <= 8'd0;
      bus.tray          <= 6'd0;
      bus.tray_amount   <= 3'd0;
      bus.current_color <= 1'b0;
      bus.no_balls      <= 1'b0;
      bus.timeout_err   <= 1'b0;
      bus.busy          <= 1'b0;
      bus.halted        <= 1'b0;
      bus.blue_release  <= 1'b0;
      bus.red_release   <= 1'b0;
    end else begin
      bus.blue_release <= 1'b0;
      bus.red_release  <= 1'b0;

      if (req) begin
        // Log the landed ball; the tray saturates once full.
        if (state == FLIGHT && bus.tray_amount < C_TRAY_SIZE) begin
          bus.tray[bus.tray_amount] <= bus.current_color;
          bus.tray_amount           <= bus.tray_amount + 3'd1;
        end
        if (req_avail) begin
          state             <= RELEASE;
          bus.busy          <= 1'b1;
          bus.current_color <= req_color;
          flight_timer      <= 8'd0;
          if (req_color) begin
            bus.red_release <= 1'b1;
            reds            <= reds - 5'd1;
          end else begin
            bus.blue_release <= 1'b1;
            blues            <= blues - 5'd1;
          end
        end else begin
          state        <= HALT;
          bus.no_balls <= 1'b1;
          bus.busy     <= 1'b0;
          bus.halted   <= 1'b1;
        end
      end else begin
        case (state)
          RELEASE: state <= FLIGHT;
          FLIGHT: begin
            if (flight_timer == C_TIMEOUT) begin
              state           <= HALT;
              bus.timeout_err <= 1'b1;
              bus.busy        <= 1'b0;
              bus.halted      <= 1'b1;
            end else begin
              flight_timer <= flight_timer + 8'd1;
            end
          end
          default: ;  // IDLE waits for start, HALT holds until reset
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ball_sequencer.sv
// ============================================================================
//  Module      : tb_ball_sequencer
//  Description : Self-checking bench for ball_sequencer. Expected release
//                pulses are queued when stimulus is driven and matched when
//                the design emits them; status outputs are compared against
//                a small behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ball_sequencer;

  localparam int TO = 255;

  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   cyc  = 0;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ball_sequencer_if bus0();
  ball_sequencer_if bus1();

  ball_sequencer #(.AMOUNT_BLUE(8), .AMOUNT_RED(8), .TIMEOUT(TO)) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  ball_sequencer #(.AMOUNT_BLUE(1), .AMOUNT_RED(8), .TIMEOUT(TO)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard for dut0 release pulses ----------------
  typedef struct {
    int   due;
    logic color;
  } rel_t;

  rel_t exp_q[$];
  rel_t mon_e;

  always @(negedge clk) begin
    if (!rst0) begin
      if (bus0.blue_release || bus0.red_release) begin
        check("rel_excl", 32'(bus0.blue_release & bus0.red_release), 0);
        if (exp_q.size() == 0) begin
          check("rel_unexpected", 32'({bus0.blue_release, bus0.red_release}), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rel_cycle", cyc, mon_e.due);
          check("rel_color", 32'(bus0.red_release), 32'(mon_e.color));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
        check("rel_missing", 32'(bus0.blue_release | bus0.red_release), 1);
        void'(exp_q.pop_front());
      end
    end
  end

  int rel1_count = 0;
  always @(negedge clk) begin
    if (bus1.blue_release || bus1.red_release) rel1_count++;
  end

  // ---------------- model of dut0 ----------------
  int         m_blues, m_reds, m_amt;
  logic       m_color;
  logic [5:0] m_tray;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    tick();
    tick();
    rst0    = 1'b0;
    m_blues = 8;
    m_reds  = 8;
    m_amt   = 0;
    m_tray  = '0;
    m_color = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset0(input string pfx);
    check({pfx, "_blue_rel"}, 32'(bus0.blue_release), 0);
    check({pfx, "_red_rel"},  32'(bus0.red_release),  0);
    check({pfx, "_busy"},     32'(bus0.busy),         0);
    check({pfx, "_halted"},   32'(bus0.halted),       0);
    check({pfx, "_no_balls"}, 32'(bus0.no_balls),     0);
    check({pfx, "_timeout"},  32'(bus0.timeout_err),  0);
    check({pfx, "_color"},    32'(bus0.current_color), 0);
    check({pfx, "_tray"},     32'(bus0.tray),         0);
    check({pfx, "_tray_amt"}, 32'(bus0.tray_amount),  0);
    check({pfx, "_blues"},    32'(dut0.blues),        8);
    check({pfx, "_reds"},     32'(dut0.reds),         8);
  endtask

  // Request a ball of 'color' from the model's point of view.
  task automatic model_request(input logic color);
    if ((color ? m_reds : m_blues) > 0) begin
      exp_q.push_back('{due: cyc + 1, color: color});
      if (color) m_reds--; else m_blues--;
      m_color = color;
    end
  endtask

  task automatic launch0(input logic color);
    bus0.start       = 1'b1;
    bus0.start_color = color;
    model_request(color);
    tick();
    bus0.start = 1'b0;
  endtask

  // Lever pulse on dut0 while a ball is in FLIGHT.
  task automatic lever0(input logic b, input logic r);
    bus0.blue_lever = b;
    bus0.red_lever  = r;
    if (m_amt < 6) begin
      m_tray[m_amt] = m_color;
      m_amt++;
    end
    model_request(!b);
    tick();
    bus0.blue_lever = 1'b0;
    bus0.red_lever  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.start = 0; bus0.start_color = 0; bus0.blue_lever = 0; bus0.red_lever = 0;
    bus1.start = 0; bus1.start_color = 0; bus1.blue_lever = 0; bus1.red_lever = 0;

    // ---- reset state, red launch ----
    reset0();
    check_reset0("rst");
    launch0(1'b1);
    check("s1_red_rel", 32'(bus0.red_release), 1);
    check("s1_reds",    32'(dut0.reds), 32'(m_reds));
    check("s1_color",   32'(bus0.current_color), 1);
    check("s1_busy",    32'(bus0.busy), 1);
    tick();
    check("s1_rel_one_cycle", 32'(bus0.red_release), 0);

    // ---- blue lever ~10 cycles after launch ----
    repeat (8) tick();
    lever0(1'b1, 1'b0);
    check("s2_tray0",    32'(bus0.tray[0]), 1);
    check("s2_tray_amt", 32'(bus0.tray_amount), 1);
    check("s2_blue_rel", 32'(bus0.blue_release), 1);
    check("s2_blues",    32'(dut0.blues), 32'(m_blues));

    // ---- both levers together: blue wins ----
    tick();
    lever0(1'b1, 1'b1);
    check("s4_blue_rel", 32'(bus0.blue_release), 1);
    check("s4_red_rel",  32'(bus0.red_release), 0);
    check("s4_reds",     32'(dut0.reds), 32'(m_reds));
    check("s4_tray",     32'(bus0.tray), 32'(m_tray));

    // ---- timeout: no lever after this release ----
    repeat (TO + 1) tick();
    check("to_not_yet", 32'(bus0.timeout_err), 0);
    check("to_busy",    32'(bus0.busy), 1);
    tick();
    check("to_err",    32'(bus0.timeout_err), 1);
    check("to_halted", 32'(bus0.halted), 1);
    check("to_busy0",  32'(bus0.busy), 0);
    // HALT ignores start and levers
    bus0.start = 1'b1; bus0.blue_lever = 1'b1; bus0.red_lever = 1'b1;
    tick();
    bus0.start = 1'b0; bus0.blue_lever = 1'b0; bus0.red_lever = 1'b0;
    tick();
    check("halt_stays",   32'(bus0.halted), 1);
    check("halt_tray_am", 32'(bus0.tray_amount), 32'(m_amt));

    // ---- seven landings, tray saturation, reset mid-flight ----
    reset0();
    check_reset0("rst2");
    launch0(1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      lever0((i % 2) == 1, (i % 2) == 0);
      check($sformatf("sat_amt%0d", i),  32'(bus0.tray_amount), 32'(m_amt));
      check($sformatf("sat_tray%0d", i), 32'(bus0.tray), 32'(m_tray));
      tick();
    end
    check("sat_amt_final", 32'(bus0.tray_amount), 6);
    check("sat_busy",      32'(bus0.busy), 1);
    // reset together with a lever: the pending release must be dropped
    rst0 = 1'b1;
    bus0.blue_lever = 1'b1;
    exp_q.delete();
    tick();
    rst0 = 1'b0;
    bus0.blue_lever = 1'b0;
    m_blues = 8; m_reds = 8; m_amt = 0; m_tray = '0; m_color = 1'b0;
    check_reset0("midrst");
    tick();
    check("midrst_no_rel", 32'({bus0.blue_release, bus0.red_release}), 0);

    // ---- AMOUNT_BLUE=1: supply exhaustion on dut1 ----
    rst1 = 1'b1;
    tick();
    tick();
    rst1 = 1'b0;
    bus1.start = 1'b1; bus1.start_color = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("nb_red_rel", 32'(bus1.red_release), 1);
    tick();
    bus1.blue_lever = 1'b1;           // held two cycles; second lands in RELEASE
    tick();
    check("nb_blue_rel", 32'(bus1.blue_release), 1);
    check("nb_blues0",   32'(dut1.blues), 0);
    tick();
    bus1.blue_lever = 1'b0;
    check("nb_rel_once", 32'(bus1.blue_release), 0);
    check("nb_busy",     32'(bus1.busy), 1);
    check("nb_nb0",      32'(bus1.no_balls), 0);
    bus1.blue_lever = 1'b1;
    tick();
    bus1.blue_lever = 1'b0;
    check("nb_no_balls", 32'(bus1.no_balls), 1);
    check("nb_halted",   32'(bus1.halted), 1);
    check("nb_no_rel",   32'({bus1.blue_release, bus1.red_release}), 0);
    check("nb_tray_amt", 32'(bus1.tray_amount), 2);
    check("nb_tray",     32'(bus1.tray), 32'(6'b000001));
    bus1.red_lever = 1'b1;
    tick();
    bus1.red_lever = 1'b0;
    repeat (3) tick();
    check("nb_rel_count", rel1_count, 2);
    check("nb_q_empty",   exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
